// File: rtl/rr_encode_arb_pkg.sv
// Shared types and defaults for the round-robin encode arbiter.
// Holds the FSM state encoding and the default index width.
package rr_encode_arb_pkg;

  localparam int RR_N_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_encode_arb_pick.sv
// rr_pick: combinational circular-priority search.
// Returns the first set request at or above i_ptr, wrapping at M.
module rr_pick
  import rr_encode_arb_pkg::*;
#(
  parameter int N = RR_N_DEF,
  parameter int M = 1 << N
) (
  input  logic [M-1:0] i_req,
  input  logic [N-1:0] i_ptr,
  output logic         o_vld,
  output logic [N-1:0] o_idx
);

  logic [N-1:0] w_cand;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = i_ptr;
    w_cand = '0;
    for (int k = M - 1; k >= 0; k--) begin
      w_cand = i_ptr + N'(k);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_encode_arb.sv
// Round-robin arbiter with encoded grant index (M = 1<<N).
// Define RR_ENCODE_ARB_LOCK_EN to add a lock input that holds on ack.
module rr_encode_arb
  import rr_encode_arb_pkg::*;
#(
  parameter int N = RR_N_DEF,
  parameter int M = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         ack,
`ifdef RR_ENCODE_ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic [M-1:0] gnt,
  output logic [N-1:0] gnt_idx,
  output logic         gnt_vld
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [N-1:0] r_ptr;
  logic [N-1:0] w_ptr_nxt;
  logic [N-1:0] r_idx;
  logic [N-1:0] w_idx_nxt;
  logic         w_pick_vld;
  logic [N-1:0] w_pick_idx;
  logic         w_lock;
  logic         w_release;

`ifdef RR_ENCODE_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  rr_pick #(
    .N (N),
    .M (M)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  // Abandon always releases; ack releases unless locked.
  assign w_release = !req[r_idx] || (ack && !w_lock);

  // State, pointer and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: pick in IDLE, hold or release in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_idx_nxt   = w_pick_idx;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt   = r_idx + 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign gnt_vld = (r_state == ST_GRANT);
  assign gnt_idx = r_idx;
  assign gnt     = gnt_vld ? (M'(1) << r_idx) : '0;

endmodule

// File: tb/tb_rr_encode_arb.sv
// Self-checking bench for rr_encode_arb (N=2, M=4).
// Directed literal checks plus a random run against a queue-free model.
module tb_rr_encode_arb;

  localparam int N = 2;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [M-1:0] req = '0;
  logic         ack = 1'b0;
  logic         lock = 1'b0;
  logic [M-1:0] gnt;
  logic [N-1:0] gnt_idx;
  logic         gnt_vld;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  rr_encode_arb #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
`ifdef RR_ENCODE_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: who holds the grant and where the search starts next.
  int m_vld = 0;
  int m_idx = 0;
  int m_ptr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 0;
      m_idx <= 0;
      m_ptr <= 0;
    end else if (m_vld == 0) begin
      for (int k = M - 1; k >= 0; k--) begin
        if (req[(m_ptr + k) % M]) begin
          m_idx <= (m_ptr + k) % M;
          m_vld <= 1;
        end
      end
    end else if (!req[m_idx] || (ack && !lock)) begin
      m_vld <= 0;
      m_ptr <= (m_idx + 1) % M;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("mdl_gnt", int'(gnt), m_vld ? (1 << m_idx) : 0);
      chk("mdl_idx", int'(gnt_idx), m_idx);
      chk("mdl_vld", int'(gnt_vld), m_vld);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rel();
    ack = 1'b1;
    lock = 1'b0;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    int seq [4];
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0;
    repeat (3) cyc();
    run = 1'b1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_vld", int'(gnt_vld), 0);
    chk("rst_idx", int'(gnt_idx), 0);

    // Rotation over all four requesters.
    req = 4'b1111;
    rst_n = 1'b1;
    cyc();
    chk("rot_first", int'(gnt_idx), 0);
    chk("rot_first_vld", int'(gnt_vld), 1);
    foreach (seq[i]) begin
      rel();
      chk("rot_gap", int'(gnt_vld), 0);
      cyc();
      chk("rot_vld", int'(gnt_vld), 1);
      chk("rot_idx", int'(gnt_idx), seq[i]);
    end
    rel();
    req = 4'b0000;
    cyc();

    // Top requester, then pointer wrap to 0.
    req = 4'b1000;
    cyc();
    chk("wrap_gnt", int'(gnt), 8);
    chk("wrap_idx", int'(gnt_idx), 3);
    rel();
    req = 4'b1001;
    cyc();
    chk("wrap_next", int'(gnt_idx), 0);
    rel();
    req = 4'b0000;
    cyc();

    // Abandon by requester 2 moves pointer to 3.
    req = 4'b0100;
    cyc();
    chk("ab_idx", int'(gnt_idx), 2);
    req = 4'b0000;
    cyc();
    chk("ab_vld", int'(gnt_vld), 0);
    req = 4'b1111;
    cyc();
    chk("ab_ptr", int'(gnt_idx), 3);
    rel();
    req = 4'b0000;
    cyc();

    // Idle with stray acks.
    for (int i = 0; i < 10; i++) begin
      ack = i[0];
      cyc();
      chk("idle_vld", int'(gnt_vld), 0);
    end
    ack = 1'b0;
    req = 4'b1111;
    cyc();
    chk("idle_ptr", int'(gnt_idx), 0);
    rel();
    req = 4'b0100;
    cyc();
    chk("pre_rst", int'(gnt_idx), 2);

    // Asynchronous reset mid-grant.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_vld", int'(gnt_vld), 0);
    chk("arst_idx", int'(gnt_idx), 0);
    cyc();
    req = 4'b0110;
    rst_n = 1'b1;
    cyc();
    chk("arst_first", int'(gnt_idx), 1);
    rel();
    req = 4'b0000;
    cyc();

`ifdef RR_ENCODE_ARB_LOCK_EN
    req = 4'b0010;
    cyc();
    chk("lk_idx", int'(gnt_idx), 1);
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1;
      lock = 1'b1;
      cyc();
      ack = 1'b0;
      lock = 1'b0;
      chk("lk_hold_vld", int'(gnt_vld), 1);
      chk("lk_hold_idx", int'(gnt_idx), 1);
    end
    rel();
    chk("lk_rel", int'(gnt_vld), 0);
    cyc();
    chk("lk_ptr", int'(gnt_idx), 2);
    rel();
    req = 4'b0000;
    cyc();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = gnt;
      ack = ($urandom_range(0, 2) == 0);
`ifdef RR_ENCODE_ARB_LOCK_EN
      lock = $urandom_range(0, 1) == 1;
`endif
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_encode_arb.md
RR_ENCODE_ARB -- requirements
Module: rr_encode_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning grant-index width in bits.
REQ-002 SHALL have parameter M, default 1<<N, meaning number of requesters; M SHALL equal 1<<N.
REQ-003 SHALL have port clk, input, 1, meaning sole clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port req, input, M, meaning request vector with one bit per requester.
REQ-006 SHALL have port ack, input, 1, meaning the granted requester finished, valid only while gnt_vld=1.
REQ-007 SHALL have port gnt, output, M, meaning one-hot grant vector, all-zero when idle.
REQ-008 SHALL have port gnt_idx, output, N, meaning binary index of the granted requester.
REQ-009 SHALL have port gnt_vld, output, 1, meaning a grant is held.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and GRANT, with registered outputs.
REQ-011 SHALL, in IDLE with req!=0, select the lowest index i with req[i]=1 searching circularly upward from ptr, and enter GRANT on the next edge.
REQ-012 SHALL assert gnt=1<<i, gnt_idx=i and gnt_vld=1 exactly one cycle after the request is sampled in IDLE.
REQ-013 SHALL stay in IDLE with gnt=0, gnt_vld=0 and gnt_idx unchanged while req=0.
REQ-014 SHALL hold gnt, gnt_idx and gnt_vld stable in GRANT until release, regardless of other req bits.
REQ-015 SHALL release in GRANT on ack=1, or on req[gnt_idx]=0 (abandon); release SHALL set ptr=(gnt_idx+1) mod M and return to IDLE.
REQ-016 SHALL deassert gnt and gnt_vld the cycle after release, giving exactly one idle cycle between consecutive grants.
REQ-017 SHALL compute ptr wrap in N bits, so gnt_idx=M-1 yields ptr=0.
REQ-018 SHALL treat ack=1 together with req[gnt_idx]=0 as a single release, advancing ptr once.
REQ-019 SHALL ignore ack while in IDLE.
REQ-020 SHALL keep gnt one-hot or zero in every cycle, and SHALL keep gnt_idx equal to the encoded value of gnt whenever gnt_vld=1.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-grant, immediately force IDLE, ptr=0, gnt=0, gnt_idx=0 and gnt_vld=0.
REQ-022 SHALL sample requests on the first rising clk edge after rst_n deasserts, so the first grant appears one cycle later.

Configuration
REQ-023 SHALL, with macro RR_ENCODE_ARB_LOCK_EN defined, add input port lock (1 bit); ack with lock=1 in GRANT SHALL keep the grant with the same requester and leave ptr unchanged; ack with lock=0 SHALL release normally; abandon SHALL release regardless of lock.
REQ-024 SHALL, without RR_ENCODE_ARB_LOCK_EN, have no lock port, and ack SHALL always release.

Structure
REQ-025 SHALL place the FSM state encodings (IDLE=0, GRANT=1) and the default N in shared package rr_encode_arb_pkg.
REQ-026 SHALL contain one combinational sub-module, rr_pick, that takes req and ptr and returns a valid flag plus the circular-priority winner index; gnt SHALL be decoded from the registered index.

Verification (N=2, M=4)
REQ-027 SHALL check: reset, then req=4'b1111 held and ack pulsed once per grant -> gnt_idx sequence 0,1,2,3,0, with one idle cycle between grants.
REQ-028 SHALL check: req=4'b1000 with ack -> gnt=4'b1000 and gnt_idx=3, ptr wraps to 0; then req=4'b1001 -> gnt_idx=0.
REQ-029 SHALL check: requester 2 granted, then req[2] dropped without ack -> gnt_vld=0 next cycle and ptr=3.
REQ-030 SHALL check: rst_n pulsed low mid-grant -> gnt=0, gnt_vld=0 and gnt_idx=0 asynchronously, and with req=4'b0110 after reset the first grant is gnt_idx=1.
REQ-031 SHALL check: req=0 for 10 cycles -> gnt_vld stays 0, and ack pulses are ignored.
REQ-032 SHALL check, with RR_ENCODE_ARB_LOCK_EN: requester 1 granted, ack with lock=1 twice -> gnt_idx stays 1; then ack with lock=0 -> release and ptr=2.
